weight_gemm_streamer: RTL and testbench

WEIGHT_GEMM_STREAMER -- requirements
Module: weight_gemm_streamer

---
 rtl/weight_gemm_streamer.sv | 114 +++++++++++
 tb/tb_weight_gemm_streamer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/weight_gemm_streamer.sv
// Holds one K x L weight matrix and replays it column by column to a GEMM array.
// The whole matrix is sent num_pass times, with no gap between passes.
// state    | meaning
// S_IDLE   | waiting for a matrix, load_ready high
// S_STREAM | presenting column r_col of pass r_pass
// S_DONE   | one-cycle done pulse, then back to idle
module weight_gemm_streamer #(
  parameter int K  = 10,
  parameter int C  = 3,
  parameter int wH = 5,
  parameter int BW = 16,
  localparam int L  = C*wH*wH,
  localparam int IW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] iWeight_rearranged [0:K-1][0:L-1],
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [15:0]   num_pass,
  output logic [BW-1:0] out_data [0:K-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_col_last,
  output logic          out_pass_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [IW-1:0] COL_LAST = IW'(L-1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_buf [0:K-1][0:L-1];
  logic [IW-1:0] r_col;
  logic [15:0]   r_pass;
  logic [15:0]   r_num_pass;
  logic          w_load;
  logic          w_fire;
  logic          w_col_last;
  logic          w_pass_last;

  assign w_col_last  = (r_col == COL_LAST);
  assign w_pass_last = (r_pass == (r_num_pass - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          w_fire = 1'b1;
          if (w_col_last && w_pass_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Passes only advance at a column wrap; the final wrap leaves counters parked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_pass     <= '0;
      r_num_pass <= '0;
      for (int k = 0; k < K; k++)
        for (int j = 0; j < L; j++)
          r_buf[k][j] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < K; k++)
        for (int j = 0; j < L; j++)
          r_buf[k][j] <= iWeight_rearranged[k][j];
      r_num_pass <= (num_pass == 16'd0) ? 16'd1 : num_pass;
      r_col      <= '0;
      r_pass     <= '0;
    end else if (w_fire) begin
      if (!w_col_last) begin
        r_col <= r_col + IW'(1);
      end else if (!w_pass_last) begin
        r_col  <= '0;
        r_pass <= r_pass + 16'd1;
      end
    end
  end

  assign load_ready    = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_STREAM);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign out_idx       = r_col;
  assign out_col_last  = out_valid && w_col_last;
  assign out_pass_last = out_valid && w_pass_last;

  always_comb begin
    for (int k = 0; k < K; k++) out_data[k] = r_buf[k][r_col];
  end

endmodule

// File: tb/tb_weight_gemm_streamer.sv
// Self-checking bench for weight_gemm_streamer: randomized back-pressure and data,
// compared against an expected-beat queue built from the matrix and pass count.
module tb_weight_gemm_streamer;

  localparam int K  = 10;
  localparam int L  = 75;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   iWeight_rearranged [0:K-1][0:L-1];
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   num_pass;
  logic [15:0]   out_data [0:K-1];
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_col_last;
  logic          out_pass_last;
  logic          busy;
  logic          done;

  logic [15:0]   m_cur [0:K-1][0:L-1];
  logic [15:0]   m_alt [0:K-1][0:L-1];
  logic [15:0]   exp_mat [0:K-1][0:L-1];

  int n_checks = 0;
  int n_errors = 0;

  weight_gemm_streamer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .iWeight_rearranged (iWeight_rearranged),
    .load_valid         (load_valid),
    .load_ready         (load_ready),
    .num_pass           (num_pass),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_idx            (out_idx),
    .out_col_last       (out_col_last),
    .out_pass_last      (out_pass_last),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < L; j++)
        m_cur[k][j] = 16'(k*100 + j);
  endtask

  task automatic fill_random_alt();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < L; j++)
        m_alt[k][j] = 16'($urandom_range(0, 65535));
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_load(input int np, input int rdy_pct, input int abort_beat, input bit hold_alt);
    int q_idx[$];
    bit q_pl[$];
    int n_eff, beats, cyc, limit, idx;
    bit prev_fire, fin;
    n_eff = (np == 0) ? 1 : np;
    for (int p = 0; p < n_eff; p++)
      for (int j = 0; j < L; j++) begin
        q_idx.push_back(j);
        q_pl.push_back(p == n_eff - 1);
      end
    exp_mat = m_cur;
    iWeight_rearranged = m_cur;
    num_pass   = 16'(np);
    load_valid = 1'b1;
    check_val("load_ready_idle", load_ready, 1);
    beats = 0; cyc = 0; prev_fire = 0; fin = 0;
    limit = n_eff * L * 20 + 50;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (hold_alt) iWeight_rearranged = m_alt;
      else          load_valid = 1'b0;
      if (cyc > limit) begin
        check_val("timeout", 1, 0);
        fin = 1;
      end else if (abort_beat >= 0 && beats == abort_beat) begin
        check_val("pre_abort_valid", out_valid, 1);
        rst_n = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_ready", load_ready, 1);
        check_val("abort_done", done, 0);
        for (int k = 0; k < K; k++) check_val("abort_data", out_data[k], 0);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_val("post_abort_done", done, 0);
          check_val("post_abort_valid", out_valid, 0);
        end
        fin = 1;
      end else if (q_idx.size() != 0) begin
        idx = q_idx[0];
        check_val("valid", out_valid, 1);
        check_val("done_early", done, 0);
        check_val("busy", busy, 1);
        check_val("load_ready_busy", load_ready, 0);
        check_val("idx", out_idx, idx);
        check_val("col_last", out_col_last, idx == L-1);
        check_val("pass_last", out_pass_last, q_pl[0]);
        for (int k = 0; k < K; k++) check_val("data", out_data[k], exp_mat[k][idx]);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        prev_fire = out_ready;
        if (out_ready) begin
          void'(q_idx.pop_front());
          void'(q_pl.pop_front());
          beats++;
        end
      end else begin
        check_val("done_pulse", done, prev_fire);
        check_val("done_valid", out_valid, 0);
        check_val("done_busy", busy, 1);
        check_val("done_ready", load_ready, 0);
        check_val("beat_count", beats, n_eff * L);
        @(negedge clk);
        check_val("idle_done", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_valid", out_valid, 0);
        check_val("idle_ready", load_ready, 1);
        fin = 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b0;
    num_pass = 16'd0;
    fill_pattern();
    iWeight_rearranged = m_cur;
    repeat (3) @(negedge clk);
    check_val("rst_ready", load_ready, 1);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    for (int k = 0; k < K; k++) check_val("rst_data", out_data[k], 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_load(1, 100, -1, 0);
    run_load(3, 100, -1, 0);
    run_load(0, 100, -1, 0);
    run_load(1, 30, -1, 0);

    fill_random_alt();
    m_cur = m_alt;
    run_load(2, 60, -1, 0);

    fill_pattern();
    fill_random_alt();
    run_load(1, 100, -1, 1);
    m_cur = m_alt;
    run_load(1, 100, -1, 0);

    fill_pattern();
    run_load(1, 100, 40, 0);
    fill_random_alt();
    m_cur = m_alt;
    run_load(1, 70, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
